// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - shared types and constants for the ESM shuffle buffer
package esm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_SHUFFLE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_1D5B;

    // occupancy count must hold 0..bs inclusive
    function automatic int cw_of(input int bs);
        return $clog2(bs) + 1;
    endfunction

endpackage

// File: rtl/shuffle_ctrl_slot_select.sv
// rtl/shuffle_ctrl_slot_select.sv - combinational k-th set bit finder over the occupancy map
module slot_select #(
    parameter int BS = 16,
    parameter int CW = 5,
    parameter int IW = 4
) (
    input  logic [BS-1:0] occ,
    input  logic [CW-1:0] k,
    output logic [IW-1:0] slot
);
    logic [CW-1:0] seen;

    // walk set bits LSB first; the bit reached while exactly k earlier bits were set is the pick
    always_comb begin
        slot = '0;
        seen = '0;
        for (int i = 0; i < BS; i++) begin
            if (occ[i]) begin
                if (seen == k) begin
                    slot = IW'(i);
                end
                seen = seen + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shuffle_ctrl.sv
// rtl/shuffle_ctrl.sv - shuffle buffer sequencer; SHUFFLE_LFSR_EN selects the internal LFSR over rand_num
module shuffle_ctrl
    import esm_pkg::*;
#(
    parameter int          BS   = 16,
    parameter int          DW   = 32,
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          done
`ifndef SHUFFLE_LFSR_EN
    ,
    input  logic [31:0]   rand_num
`endif
);
    localparam int            CW        = cw_of(BS);
    localparam int            IW        = $clog2(BS);
    localparam logic [CW-1:0] FULL      = CW'(BS);
    localparam logic [CW-1:0] NEAR_FULL = CW'(BS - 1);

    state_e          state_q, state_d;
    logic [BS-1:0]   occ_q, occ_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            done_q, done_d;
    logic [DW-1:0]   mem_q [BS];

    logic            accept, fire, pop_en, pop;
    logic [IW-1:0]   wr_idx, sel_idx;
    logic [CW-1:0]   k;
    logic [15:0]     divisor;
    logic [31:0]     rand_w;
    logic            unused_rand_hi;

`ifdef SHUFFLE_LFSR_EN
    logic [31:0] lfsr_q, lfsr_d;

    // free-running Galois LFSR, one step per cycle
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_w = lfsr_q;
`else
    logic [31:0] unused_seed;
    assign unused_seed = SEED;
    assign rand_w      = rand_num;
`endif

    assign unused_rand_hi = ^rand_w[31:16];

    // rank of the slot to pop among occupied slots; divisor guarded so idle cycles never divide by zero
    always_comb begin
        divisor = (count_q == '0) ? 16'd1 : 16'(count_q);
        k       = CW'(rand_w[15:0] % divisor);
    end

    // lowest-index free slot receives the next accepted word
    always_comb begin
        wr_idx = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                wr_idx = IW'(i);
            end
        end
    end

    slot_select #(.BS(BS), .CW(CW), .IW(IW)) u_slot_select (
        .occ  (occ_q),
        .k    (k),
        .slot (sel_idx)
    );

    // sequencing: handshakes, occupancy/count bookkeeping, output register and state transitions
    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        accept = in_valid & in_ready_q;
        fire   = out_valid_q & out_ready;
        case (state_q)
            ST_SHUFFLE: pop_en = (count_q >= NEAR_FULL);
            ST_DRAIN:   pop_en = (count_q != '0);
            default:    pop_en = 1'b0;
        endcase
        pop = pop_en & (~out_valid_q | fire);

        // write slot is free pre-edge and the popped slot is occupied, so they never collide
        if (accept) begin
            occ_d[wr_idx] = 1'b1;
        end
        if (pop) begin
            occ_d[sel_idx] = 1'b0;
            out_valid_d    = 1'b1;
            out_data_d     = mem_q[sel_idx];
        end else if (fire) begin
            out_valid_d = 1'b0;
        end

        count_d = count_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, pop};

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (accept && in_last)  state_d = ST_DRAIN;
                else if (count_d == FULL) state_d = ST_SHUFFLE;
            end
            ST_SHUFFLE: begin
                if (accept && in_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (count_q == '0 && !out_valid_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = ((state_d == ST_FILL) || (state_d == ST_SHUFFLE)) && (count_d < FULL);
    end

    // control and output registers; reset discards any buffered frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            occ_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    // slot storage; validity lives entirely in the occupancy map
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_idx] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shuffle_ctrl.sv
// tb/tb_shuffle_ctrl.sv - scoreboard bench for shuffle_ctrl with a queue-based reference model
module tb_shuffle_ctrl;
    import esm_pkg::*;

    localparam int BS = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   rand_num = '0;
    logic          in_ready, out_valid, done;
    logic [DW-1:0] out_data;

    int n_cmp = 0;
    int n_fail = 0;
    bit rzero = 1'b0;

    shuffle_ctrl #(.BS(BS), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .done      (done),
        .rand_num  (rand_num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: phases 0 idle, 1 fill, 2 shuffle, 3 drain; slots as a plain array
    int            m_state = 0;
    int            m_count = 0;
    bit            m_occ [BS];
    logic [DW-1:0] m_mem [BS];
    bit            m_in_ready = 1'b0;
    bit            m_out_valid = 1'b0;
    bit            m_done = 1'b0;
    logic [DW-1:0] exp_q [$];

    always @(posedge clk or negedge rst_n) begin : model_step
        bit acc, fire, pop;
        int w, k, nxt;
        int occupied [$];
        if (!rst_n) begin
            m_state = 0; m_count = 0; m_in_ready = 0; m_out_valid = 0; m_done = 0;
            for (int i = 0; i < BS; i++) m_occ[i] = 0;
            exp_q.delete();
        end else begin
            acc  = in_valid && m_in_ready;
            fire = m_out_valid && out_ready;
            pop  = ((m_state == 2 && m_count >= BS - 1) || (m_state == 3 && m_count > 0))
                   && (!m_out_valid || fire);
            occupied.delete();
            for (int i = 0; i < BS; i++) if (m_occ[i]) occupied.push_back(i);
            w = -1;
            for (int i = BS - 1; i >= 0; i--) if (!m_occ[i]) w = i;
            nxt = m_state;
            m_done = 0;
            if (m_state == 3 && m_count == 0 && !m_out_valid) begin
                nxt = 0;
                m_done = 1;
            end
            if (pop) begin
                k = int'(rand_num[15:0]) % m_count;
                exp_q.push_back(m_mem[occupied[k]]);
                m_occ[occupied[k]] = 0;
                m_out_valid = 1;
            end else if (fire) begin
                m_out_valid = 0;
            end
            if (acc) begin
                m_occ[w] = 1;
                m_mem[w] = in_data;
            end
            m_count = m_count + int'(acc) - int'(pop);
            case (m_state)
                0: if (start) nxt = 1;
                1: if (acc && in_last) nxt = 3; else if (m_count == BS) nxt = 2;
                2: if (acc && in_last) nxt = 3;
                default: ;
            endcase
            m_state = nxt;
            m_in_ready = (nxt == 1 || nxt == 2) && (m_count < BS);
        end
    end

    // monitor: compare handshake outputs each cycle, retire scoreboard entries on fire
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_fire_cyc = 0;
    logic [DW-1:0] out_log [$];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'(m_in_ready));
            chk("out_valid", 64'(out_valid), 64'(m_out_valid));
            chk("done", 64'(done), 64'(m_done));
            chk("count", 64'(dut.count_q), 64'(m_count));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_data: got 0x%0h, expected no word pending at %0t", out_data, $time);
                end else begin
                    chk("out_data", 64'(out_data), 64'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        out_log.push_back(out_data);
                        last_fire_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_stats();
        done_cnt = 0;
        out_log.delete();
    endtask

    task automatic send(input int n, input int base, input bit last, input int vprob, input int rprob);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 2000) begin
            in_valid  = ($urandom_range(99) < vprob);
            in_data   = DW'(base + idx);
            in_last   = last && (idx == n - 1);
            out_ready = ($urandom_range(99) < rprob);
            rand_num  = rzero ? 32'd0 : $urandom;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("send_accepted", 64'(idx), 64'(n));
    endtask

    task automatic stream(input int cycles, input int rprob, inout int idx);
        for (int c = 0; c < cycles; c++) begin
            in_valid  = 1'b1;
            in_data   = DW'(500 + idx);
            in_last   = 1'b0;
            out_ready = ($urandom_range(99) < rprob);
            rand_num  = $urandom;
            @(negedge clk);
            if (in_ready) idx++;
            tick();
        end
    endtask

    task automatic wait_done(input int rprob);
        int g = 0;
        while (done_cnt == 0 && g < 400) begin
            out_ready = ($urandom_range(99) < rprob) || (g > 300);
            rand_num  = rzero ? 32'd0 : $urandom;
            tick();
            g++;
        end
        out_ready = 1'b1;
        repeat (3) tick();
        chk("done_seen", 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic check_perm(input int n, input int base);
        chk("log_size", 64'(out_log.size()), 64'(n));
        for (int v = 0; v < n; v++) begin
            int c = 0;
            foreach (out_log[j]) if (out_log[j] == DW'(base + v)) c++;
            chk($sformatf("value_%0d_once", base + v), 64'(c), 64'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic [DW-1:0] held;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(dut.count_q), 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        tick();
        rst_n = 1'b1;
        tick();

        // 40 words through a 16-slot buffer at full rate
        clear_stats();
        pulse_start();
        send(40, 0, 1'b1, 100, 100);
        wait_done(100);
        check_perm(40, 0);
        chk("t1_done_once", 64'(done_cnt), 64'd1);
        chk("t1_state_idle", 64'(dut.state_q), 64'(ST_IDLE));

        // rand_num held at zero: always the lowest occupied slot
        rzero = 1'b1;
        clear_stats();
        pulse_start();
        send(16, 0, 1'b1, 100, 100);
        wait_done(100);
        chk("t2_log_size", 64'(out_log.size()), 64'd16);
        for (int i = 0; i < 16 && i < out_log.size(); i++)
            chk($sformatf("t2_order_%0d", i), 64'(out_log[i]), 64'(i));
        rzero = 1'b0;

        // short frame straight from FILL to DRAIN
        clear_stats();
        pulse_start();
        send(3, 200, 1'b1, 100, 100);
        wait_done(100);
        check_perm(3, 200);
        chk("t3_done_once", 64'(done_cnt), 64'd1);
        chk("t3_done_after_fire", 64'(done_cyc - last_fire_cyc), 64'd2);

        // in_valid in IDLE, start pulses in FILL and DRAIN
        clear_stats();
        in_valid = 1'b1;
        in_data  = 32'd77;
        repeat (5) tick();
        in_valid = 1'b0;
        chk("t6_idle_count", 64'(dut.count_q), 64'd0);
        pulse_start();
        send(5, 300, 1'b0, 100, 100);
        pulse_start();
        send(2, 305, 1'b1, 100, 100);
        pulse_start();
        wait_done(100);
        check_perm(7, 300);
        chk("t6_done_once", 64'(done_cnt), 64'd1);

        // randomized valid and ready
        clear_stats();
        pulse_start();
        send(35, 400, 1'b1, 70, 60);
        wait_done(60);
        check_perm(35, 400);
        chk("t5_done_once", 64'(done_cnt), 64'd1);

        // downstream stall in SHUFFLE, then reset mid-frame
        clear_stats();
        idx = 0;
        pulse_start();
        stream(24, 100, idx);
        stream(1, 0, idx);
        held = out_data;
        stream(9, 0, idx);
        in_valid = 1'b0;
        chk("t4_out_stable", 64'(out_data), 64'(held));
        chk("t4_out_valid", 64'(out_valid), 64'd1);
        chk("t4_count_full", 64'(dut.count_q), 64'(BS));
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        chk("t4_state", 64'(dut.state_q), 64'(ST_SHUFFLE));
        rst_n = 1'b0;
        #1;
        chk("t4_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t4_rst_in_ready", 64'(in_ready), 64'd0);
        chk("t4_rst_count", 64'(dut.count_q), 64'd0);
        chk("t4_rst_out_data", 64'(out_data), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t4_post_state", 64'(dut.state_q), 64'(ST_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
